// File: rtl/cd101_trig_seq.sv
// SPI-configured trigger sequencer: oversampled SPI slave writes a small
// register file; a trig rising edge launches a delayed pulse train on data.
module cd101_trig_seq #(
    parameter int SYNC_STAGES = 2,
    parameter int DW          = 12
) (
    input  logic clk,
    input  logic rstn,
    input  logic spi_clk,
    input  logic spi_mosi,
    input  logic spi_nss,
    input  logic trig,
    output logic data,
    output logic busy
);

    localparam int SW = SYNC_STAGES + 1;
    localparam int FW = DW + 4;

    typedef enum logic [1:0] {
        S_IDLE,
        S_DELAY,
        S_HIGH,
        S_LOW
    } state_t;

    // Chains carry one extra flop past the last sync stage for edge detection.
    logic [SW-1:0]          sclk_q, sclk_d;
    logic [SW-1:0]          nss_q, nss_d;
    logic [SW-1:0]          trg_q, trg_d;
    logic [SYNC_STAGES-1:0] mosi_q, mosi_d;

    logic [FW-1:0] shift_q, shift_d;
    logic [4:0]    bcnt_q, bcnt_d;
    logic [1:0]    ctrl_q, ctrl_d;
    logic [DW-1:0] dly_q, dly_d;
    logic [DW-1:0] hi_q, hi_d;
    logic [DW-1:0] lo_q, lo_d;
    logic [DW-1:0] cnt_q, cnt_d;

    state_t        state_q, state_d;
    logic [DW-1:0] tmr_q, tmr_d;
    logic [DW-1:0] hw_q, hw_d;
    logic [DW-1:0] lw_q, lw_d;
    logic [DW-1:0] pw_q, pw_d;
    logic          data_q, data_d;
    logic          busy_q, busy_d;

    logic sclk_rise;
    logic nss_low;
    logic nss_fall;
    logic nss_rise;
    logic trg_rise;
    logic en;
    logic inv;

    function automatic logic [DW-1:0] at_least1(input logic [DW-1:0] v);
        return (v == '0) ? DW'(1) : v;
    endfunction

    assign sclk_rise = sclk_q[SW-2] & ~sclk_q[SW-1];
    assign nss_low   = ~nss_q[SW-2];
    assign nss_fall  = ~nss_q[SW-2] & nss_q[SW-1];
    assign nss_rise  = nss_q[SW-2] & ~nss_q[SW-1];
    assign trg_rise  = trg_q[SW-2] & ~trg_q[SW-1];
    assign en        = ctrl_q[0];
    assign inv       = ctrl_q[1];

    always_comb begin
        sclk_d  = {sclk_q[SW-2:0], spi_clk};
        nss_d   = {nss_q[SW-2:0], spi_nss};
        trg_d   = {trg_q[SW-2:0], trig};
        mosi_d  = {mosi_q[SYNC_STAGES-2:0], spi_mosi};
        shift_d = shift_q;
        bcnt_d  = bcnt_q;
        ctrl_d  = ctrl_q;
        dly_d   = dly_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        cnt_d   = cnt_q;
        if (nss_fall) begin
            bcnt_d = '0;
        end else if (sclk_rise && nss_low && !nss_rise) begin
            shift_d = {shift_q[FW-2:0], mosi_q[SYNC_STAGES-1]};
            if (bcnt_q != 5'd17) begin
                bcnt_d = bcnt_q + 5'd1;
            end
        end
        if (nss_rise && bcnt_q == 5'd16) begin
            case (shift_q[FW-1:DW])
                4'd0:    ctrl_d = shift_q[1:0];
                4'd1:    dly_d  = shift_q[DW-1:0];
                4'd2:    hi_d   = shift_q[DW-1:0];
                4'd3:    lo_d   = shift_q[DW-1:0];
                4'd4:    cnt_d  = shift_q[DW-1:0];
                default: ;
            endcase
        end
    end

    always_comb begin
        state_d = state_q;
        tmr_d   = tmr_q;
        hw_d    = hw_q;
        lw_d    = lw_q;
        pw_d    = pw_q;
        case (state_q)
            S_IDLE: begin
                if (trg_rise && en) begin
                    hw_d = at_least1(hi_q);
                    lw_d = at_least1(lo_q);
                    pw_d = at_least1(cnt_q);
                    if (dly_q == '0) begin
                        state_d = S_HIGH;
                        tmr_d   = at_least1(hi_q);
                    end else begin
                        state_d = S_DELAY;
                        tmr_d   = dly_q;
                    end
                end
            end
            S_DELAY: begin
                if (tmr_q == DW'(1)) begin
                    state_d = S_HIGH;
                    tmr_d   = hw_q;
                end else begin
                    tmr_d = tmr_q - DW'(1);
                end
            end
            S_HIGH: begin
                if (tmr_q == DW'(1)) begin
                    if (pw_q > DW'(1)) begin
                        pw_d    = pw_q - DW'(1);
                        state_d = S_LOW;
                        tmr_d   = lw_q;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    tmr_d = tmr_q - DW'(1);
                end
            end
            S_LOW: begin
                if (tmr_q == DW'(1)) begin
                    state_d = S_HIGH;
                    tmr_d   = hw_q;
                end else begin
                    tmr_d = tmr_q - DW'(1);
                end
            end
        endcase
        if (state_q != S_IDLE && !en) begin
            state_d = S_IDLE;
        end
        busy_d = (state_d != S_IDLE);
        data_d = (state_d == S_HIGH) ^ inv;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sclk_q  <= '0;
            nss_q   <= '1;
            trg_q   <= '0;
            mosi_q  <= '0;
            shift_q <= '0;
            bcnt_q  <= '0;
            ctrl_q  <= '0;
            dly_q   <= '0;
            hi_q    <= DW'(1);
            lo_q    <= DW'(1);
            cnt_q   <= DW'(1);
        end else begin
            sclk_q  <= sclk_d;
            nss_q   <= nss_d;
            trg_q   <= trg_d;
            mosi_q  <= mosi_d;
            shift_q <= shift_d;
            bcnt_q  <= bcnt_d;
            ctrl_q  <= ctrl_d;
            dly_q   <= dly_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            cnt_q   <= cnt_d;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= S_IDLE;
            tmr_q   <= '0;
            hw_q    <= '0;
            lw_q    <= '0;
            pw_q    <= '0;
            data_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            tmr_q   <= tmr_d;
            hw_q    <= hw_d;
            lw_q    <= lw_d;
            pw_q    <= pw_d;
            data_q  <= data_d;
            busy_q  <= busy_d;
        end
    end

    assign data = data_q;
    assign busy = busy_q;

endmodule

// File: tb/tb_cd101_trig_seq.sv
// Bench for cd101_trig_seq: register writes over SPI, then per-cycle
// data/busy checks against an expected waveform queue.
module tb_cd101_trig_seq;

    localparam int SYNC = 2;

    typedef struct {
        logic [1:0] ctrl;
        int         d;
        int         h;
        int         l;
        int         c;
        bit         wr_all;
    } vec_t;

    logic clk;
    logic rstn;
    logic spi_clk;
    logic spi_mosi;
    logic spi_nss;
    logic trig;
    logic data;
    logic busy;

    int nvec;
    int nerr;
    logic [1:0] sbq[$];
    vec_t tbl[7];

    cd101_trig_seq #(
        .SYNC_STAGES(SYNC),
        .DW(12)
    ) dut (
        .clk(clk),
        .rstn(rstn),
        .spi_clk(spi_clk),
        .spi_mosi(spi_mosi),
        .spi_nss(spi_nss),
        .trig(trig),
        .data(data),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string nm, input int k,
                       input logic ed, input logic eb);
        nvec++;
        if (data !== ed || busy !== eb) begin
            nerr++;
            $display("FAIL %s @%0d: data=%b busy=%b, expected data=%b busy=%b",
                     nm, k, data, busy, ed, eb);
        end
    endtask

    task automatic spi_frame(input logic [15:0] w, input int nb);
        @(negedge clk);
        spi_nss = 1'b0;
        cyc(4);
        for (int i = 0; i < nb; i++) begin
            spi_mosi = (i < 16) ? w[15-i] : 1'b0;
            cyc(4);
            spi_clk = 1'b1;
            cyc(4);
            spi_clk = 1'b0;
        end
        cyc(4);
        spi_nss  = 1'b1;
        spi_mosi = 1'b0;
    endtask

    task automatic wr(input logic [3:0] a, input int v);
        spi_frame({a, 12'(v)}, 16);
        cyc(6);
    endtask

    task automatic run_check(input string nm, input logic en, input logic inv,
                             input int d, input int h, input int l, input int c);
        int he;
        int le;
        int ce;
        int k;
        logic [1:0] e;
        he = (h == 0) ? 1 : h;
        le = (l == 0) ? 1 : l;
        ce = (c == 0) ? 1 : c;
        @(negedge clk);
        trig = 1'b1;
        repeat (SYNC) sbq.push_back({inv, 1'b0});
        if (en) begin
            repeat (d) sbq.push_back({inv, 1'b1});
            for (int p = 0; p < ce; p++) begin
                repeat (he) sbq.push_back({~inv, 1'b1});
                if (p < ce - 1) repeat (le) sbq.push_back({inv, 1'b1});
            end
        end
        repeat (4) sbq.push_back({inv, 1'b0});
        k = 0;
        while (sbq.size() > 0) begin
            @(posedge clk);
            #1;
            if (k == 1) trig = 1'b0;
            e = sbq.pop_front();
            chk(nm, k, e[1], e[0]);
            k++;
        end
    endtask

    initial begin
        nvec     = 0;
        nerr     = 0;
        rstn     = 1'b0;
        spi_clk  = 1'b0;
        spi_mosi = 1'b0;
        spi_nss  = 1'b1;
        trig     = 1'b0;

        tbl[0] = '{2'd1, 0, 1, 1, 1, 1'b0};
        tbl[1] = '{2'd1, 3, 2, 1, 3, 1'b1};
        tbl[2] = '{2'd1, 0, 0, 0, 0, 1'b1};
        tbl[3] = '{2'd3, 1, 1, 2, 2, 1'b1};
        tbl[4] = '{2'd1, 5, 3, 4, 1, 1'b1};
        tbl[5] = '{2'd0, 2, 2, 2, 2, 1'b1};
        tbl[6] = '{2'd1, 4095, 1, 1, 1, 1'b1};

        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            trig = ~trig;
        end
        @(posedge clk);
        #1;
        chk("reset", 0, 1'b0, 1'b0);
        @(negedge clk);
        rstn = 1'b1;
        trig = 1'b0;
        cyc(3);

        for (int i = 0; i < 7; i++) begin
            wr(4'd0, int'(tbl[i].ctrl));
            if (tbl[i].wr_all) begin
                wr(4'd1, tbl[i].d);
                wr(4'd2, tbl[i].h);
                wr(4'd3, tbl[i].l);
                wr(4'd4, tbl[i].c);
            end
            run_check($sformatf("vec%0d", i), tbl[i].ctrl[0], tbl[i].ctrl[1],
                      tbl[i].d, tbl[i].h, tbl[i].l, tbl[i].c);
        end

        wr(4'd1, 2);
        spi_frame({4'd1, 12'd7}, 15);
        cyc(6);
        spi_frame({4'd1, 12'd7}, 17);
        cyc(6);
        wr(4'd7, 9);
        run_check("short_long_frame", 1'b1, 1'b0, 2, 1, 1, 1);
        wr(4'd1, 7);
        run_check("valid_frame", 1'b1, 1'b0, 7, 1, 1, 1);

        wr(4'd1, 0);
        wr(4'd2, 2);
        wr(4'd3, 80);
        wr(4'd4, 4);
        fork
            run_check("busy_run", 1'b1, 1'b0, 0, 2, 80, 4);
            begin
                cyc(20);
                trig = 1'b1;
                cyc(3);
                trig = 1'b0;
                wr(4'd2, 5);
            end
        join
        run_check("next_high", 1'b1, 1'b0, 0, 5, 80, 4);

        wr(4'd2, 400);
        wr(4'd3, 1);
        wr(4'd4, 1);
        @(negedge clk);
        trig = 1'b1;
        cyc(2);
        trig = 1'b0;
        cyc(3);
        @(posedge clk);
        #1;
        chk("mid_high", 0, 1'b1, 1'b1);
        spi_frame({4'd0, 12'd0}, 16);
        repeat (3) @(posedge clk);
        #1;
        chk("abort_pre", 0, 1'b1, 1'b1);
        @(posedge clk);
        #1;
        chk("abort_post", 1, 1'b0, 1'b0);
        wr(4'd0, 3);
        @(posedge clk);
        #1;
        chk("inv_idle", 0, 1'b1, 1'b0);
        wr(4'd2, 2);
        wr(4'd4, 2);
        run_check("inv_run", 1'b1, 1'b1, 0, 2, 1, 2);

        wr(4'd0, 1);
        wr(4'd1, 20);
        @(negedge clk);
        trig = 1'b1;
        cyc(2);
        trig = 1'b0;
        cyc(8);
        @(posedge clk);
        #1;
        chk("pre_rst", 0, 1'b0, 1'b1);
        #2;
        rstn = 1'b0;
        #1;
        chk("rst_async", 0, 1'b0, 1'b0);
        cyc(2);
        rstn = 1'b1;
        cyc(2);
        run_check("post_rst", 1'b0, 1'b0, 0, 1, 1, 1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
